// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter register with next-PC select and an
// instruction fetch handshake FSM that includes a timeout.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        pc_write,
  input  logic [2:0]  pc_source,
  input  logic [31:0] jal,
  input  logic [31:0] branch,
  input  logic [31:0] jalr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        fetch_done,
  output logic        misaligned,
  output logic        fetch_err
);
  typedef enum logic [1:0] {BOOT, IDLE, BUSY, ERR} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, next_pc;
  logic [7:0]  cnt_q, cnt_d;
  logic        fetch_done_q, fetch_done_d, misaligned_q, misaligned_d;
  assign PC         = pc_q;
  assign imem_addr  = pc_q;
  assign PC_plus4   = pc_q + 32'd4;
  assign imem_req   = state_q == BUSY;
  assign fetch_err  = state_q == ERR;
  assign fetch_done = fetch_done_q;
  assign misaligned = misaligned_q;
  always_comb begin
    next_pc = pc_source == 3'd1 ? {jalr[31:1], 1'b0} :
              pc_source == 3'd2 ? branch :
              pc_source == 3'd3 ? jal :
              pc_source == 3'd4 ? mtvec :
              pc_source == 3'd5 ? mepc : PC_plus4;
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    fetch_done_d = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = BUSY;
        cnt_d   = 8'd0;
      end
      IDLE: if (pc_write) begin
        if (next_pc[1:0] == 2'b00) begin
          pc_d    = next_pc;
          state_d = BUSY;
          cnt_d   = 8'd0;
        end else misaligned_d = 1'b1;
      end
      BUSY: if (imem_ack) begin
        state_d      = IDLE;
        fetch_done_d = 1'b1;
        cnt_d        = 8'd0;
      end else if (cnt_q == 8'(TIMEOUT - 1)) state_d = ERR;
      else cnt_d = cnt_q + 8'd1;
      default: state_d = ERR;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      cnt_q        <= 8'd0;
      fetch_done_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      fetch_done_q <= fetch_done_d;
      misaligned_q <= misaligned_d;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int TO = 16;
  logic CLK = 0, RST_N = 1, pc_write = 0, imem_ack = 0;
  logic [2:0] pc_source = 0;
  logic [31:0] jal = 0, branch = 0, jalr = 0, mtvec = 0, mepc = 0;
  logic imem_req, fetch_done, misaligned, fetch_err;
  logic [31:0] imem_addr, PC, PC_plus4;
  int compared = 0, mismatched = 0;
  // behavioural model: mode 0 boot, 1 idle, 2 fetching, 3 error
  int m_mode, m_wait;
  logic [31:0] m_pc;
  logic m_done, m_mis;

  pc_fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .pc_write(pc_write), .pc_source(pc_source),
    .jal(jal), .branch(branch), .jalr(jalr), .mtvec(mtvec), .mepc(mepc),
    .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr), .PC(PC),
    .PC_plus4(PC_plus4), .fetch_done(fetch_done), .misaligned(misaligned),
    .fetch_err(fetch_err));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_pc = RV; m_done = 0; m_mis = 0;
  endtask

  task automatic model_edge();
    logic [31:0] t;
    logic [31:0] tg [8];
    tg = '{m_pc + 4, jalr & ~32'd1, branch, jal, mtvec, mepc, m_pc + 4, m_pc + 4};
    m_done = 0; m_mis = 0;
    if (m_mode == 0) begin m_mode = 2; m_wait = 0; end
    else if (m_mode == 1 && pc_write) begin
      t = tg[pc_source];
      if (t % 4 == 0) begin m_pc = t; m_mode = 2; m_wait = 0; end
      else m_mis = 1;
    end else if (m_mode == 2) begin
      if (imem_ack) begin m_mode = 1; m_done = 1; end
      else if (m_wait + 1 >= TO) m_mode = 3;
      else m_wait++;
    end
  endtask

  task automatic chk_all();
    chk("pc", PC, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_plus4", PC_plus4, m_pc + 32'd4);
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_mode == 2});
    chk("fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
    chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_mode == 3});
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    RST_N = 0;
    #1;
    model_reset();
    chk_all();
    @(posedge CLK);
    @(negedge CLK);
    chk_all();
    RST_N = 1;
  endtask

  function automatic logic [31:0] rtarget();
    logic [31:0] v;
    v = $urandom;
    return ($urandom_range(0, 4) == 0) ? v : (v & ~32'd3);
  endfunction

  initial begin
    model_reset();
    @(negedge CLK);
    do_reset();
    // reset fetch, ack on the third busy cycle
    step(); chk("boot_req", {31'd0, imem_req}, 32'd1); chk("boot_addr", imem_addr, 32'h0);
    step(); step();
    imem_ack = 1; step(); imem_ack = 0;
    chk("first_done", {31'd0, fetch_done}, 32'd1);
    step(); chk("done_one_pulse", {31'd0, fetch_done}, 32'd0);
    // jalr with bit0 set
    jalr = 32'h0000_0105; pc_source = 1; pc_write = 1; step(); pc_write = 0;
    chk("jalr_pc", PC, 32'h0000_0104); chk("jalr_req", {31'd0, imem_req}, 32'd1);
    pc_write = 1; step(); pc_write = 0;
    imem_ack = 1; step(); imem_ack = 0;
    // misaligned branch target
    branch = 32'h0000_0102; pc_source = 2; pc_write = 1; step(); pc_write = 0;
    chk("mis_pulse", {31'd0, misaligned}, 32'd1); chk("mis_pc", PC, 32'h0000_0104);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    step(); chk("mis_one_pulse", {31'd0, misaligned}, 32'd0);
    // wrap at top of address space
    jal = 32'hFFFF_FFFC; pc_source = 3; pc_write = 1; step(); pc_write = 0;
    imem_ack = 1; step(); imem_ack = 0;
    chk("top_plus4", PC_plus4, 32'h0);
    pc_source = 0; pc_write = 1; step(); pc_write = 0;
    chk("wrap_pc", PC, 32'h0);
    imem_ack = 1; step(); imem_ack = 0;
    // ack outside busy
    imem_ack = 1; step(); step(); imem_ack = 0;
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      pc_write = $urandom_range(0, 1); pc_source = 3'($urandom_range(0, 7));
      imem_ack = $urandom_range(0, 2) == 0;
      jal = rtarget(); branch = rtarget(); jalr = rtarget() | 32'($urandom_range(0, 1));
      mtvec = rtarget(); mepc = rtarget();
      step();
      chk("excl", {31'd0, fetch_done & misaligned}, 32'd0);
    end
    // timeout into sticky error
    pc_write = 0; imem_ack = 0;
    @(negedge CLK); do_reset();
    for (int i = 0; i < TO; i++) step();
    chk("err_at_timeout", {31'd0, fetch_err}, 32'd0);
    step();
    chk("err_set", {31'd0, fetch_err}, 32'd1); chk("err_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      pc_write = 1; pc_source = 3'($urandom_range(0, 7)); imem_ack = $urandom_range(0, 1);
      mtvec = rtarget(); step();
    end
    chk("err_sticky", {31'd0, fetch_err}, 32'd1); chk("err_pc", PC, RV);
    pc_write = 0; imem_ack = 0;
    @(negedge CLK); do_reset();
    // reset mid-fetch after moving PC away from the reset vector
    step(); imem_ack = 1; step(); imem_ack = 0;
    mtvec = 32'h0000_4000; pc_source = 4; pc_write = 1; step(); pc_write = 0;
    chk("trap_pc", PC, 32'h0000_4000);
    step();
    imem_ack = 1; RST_N = 0; #1; model_reset();
    chk("async_pc", PC, RV); chk("async_req", {31'd0, imem_req}, 32'd0);
    chk_all();
    @(posedge CLK); @(negedge CLK); chk_all();
    imem_ack = 0; RST_N = 1;
    step(); chk("refetch_req", {31'd0, imem_req}, 32'd1); chk("refetch_addr", imem_addr, RV);
    chk("no_done", {31'd0, fetch_done}, 32'd0);
    imem_ack = 1; step(); imem_ack = 0; step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, maximum BUSY cycles without imem_ack before error; legal range 2..255.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 pc_write  input  1  control FSM request to advance PC and fetch.
REQ-006 pc_source  input  3  next-PC select: 0 PC+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc, 6/7 PC+4.
REQ-007 jal, branch, jalr  input  32 each  targets from branch address generator.
REQ-008 mtvec, mepc  input  32 each  trap vector / trap return address from CSR file.
REQ-009 imem_ack  input  1  instruction memory: word at imem_addr is valid this cycle.
REQ-010 imem_req  output  1  fetch request to instruction memory.
REQ-011 imem_addr  output  32  fetch address; always equals PC.
REQ-012 PC  output  32  current program counter register.
REQ-013 PC_plus4  output  32  PC+4, combinational, modulo 2^32.
REQ-014 fetch_done  output  1  one-cycle pulse: instruction for PC available.
REQ-015 misaligned  output  1  one-cycle pulse: selected target rejected (bits[1:0] nonzero).
REQ-016 fetch_err  output  1  sticky: fetch timed out.

Function
REQ-017 FSM states SHALL be BOOT, IDLE, BUSY, ERR.
REQ-018 BOOT: imem_req=0, PC held; next edge -> BUSY with PC unchanged (fetches RESET_VECTOR).
REQ-019 IDLE, pc_write=0: all state held, imem_req=0.
REQ-020 IDLE, pc_write=1: next_pc selected per REQ-006; jalr target SHALL have bit0 forced to 0 before use.
REQ-021 IDLE, pc_write=1, next_pc[1:0]==0: PC<=next_pc, state->BUSY, wait counter<=0.
REQ-022 IDLE, pc_write=1, next_pc[1:0]!=0: PC unchanged, state stays IDLE, misaligned=1 for the following cycle only.
REQ-023 BUSY: imem_req=1 combinationally; imem_addr stable; pc_write ignored (no PC change, no misaligned).
REQ-024 BUSY, imem_ack=1: state->IDLE, fetch_done=1 the following cycle only, counter cleared.
REQ-025 BUSY, imem_ack=0: counter+1; when counter reaches TIMEOUT-1 with no ack, state->ERR.
REQ-026 ERR: imem_req=0, fetch_err=1, PC frozen, pc_write ignored; exit only via reset.
REQ-027 imem_ack outside BUSY SHALL be ignored.
REQ-028 PC+4 and all adds SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-029 fetch_done and misaligned SHALL be registered, never asserted together.

Reset
REQ-030 RST_N low SHALL immediately force: PC=RESET_VECTOR, state=BOOT, counter=0, imem_req=0, fetch_done=0, misaligned=0, fetch_err=0.
REQ-031 Reset asserted mid-BUSY SHALL abandon the fetch with no fetch_done pulse.
REQ-032 Operation resumes at first rising edge after RST_N high (BOOT->BUSY).

Verification
REQ-033 Reset release, imem_ack on 3rd BUSY cycle -> imem_addr=0x0 while req, fetch_done one pulse, state IDLE.
REQ-034 IDLE, pc_write=1, pc_source=1, jalr=0x0000_0105 -> PC=0x0000_0104, imem_req high next cycle.
REQ-035 IDLE, pc_write=1, pc_source=2, branch=0x0000_0102 -> misaligned one pulse, PC unchanged, imem_req stays 0.
REQ-036 BUSY with no ack for TIMEOUT=16 cycles -> fetch_err=1, imem_req=0; later pc_write and imem_ack have no effect until RST_N low.
REQ-037 PC=0xFFFF_FFFC, pc_source=0, pc_write=1 -> PC=0x0000_0000.
REQ-038 RST_N pulsed low during BUSY -> PC=RESET_VECTOR asynchronously, no fetch_done, BOOT->BUSY refetch after release.
